// File: rtl/ff_err_mon_if.sv
// ff_err_mon_if: FIFO status inputs and error flag/counter outputs of the FIFO error monitor
interface ff_err_mon_if #(
    parameter int NUM_INTFS = 1,
    parameter int CNTR_W    = 8
);
    logic [NUM_INTFS-1:0]        clear_flags;
    logic [NUM_INTFS-1:0]        ff_wren;
    logic [NUM_INTFS-1:0]        ff_full;
    logic [NUM_INTFS-1:0]        ff_rden;
    logic [NUM_INTFS-1:0]        ff_empty;
    logic [NUM_INTFS-1:0]        irq_mask;
    logic [NUM_INTFS-1:0]        ff_ovrflw;
    logic [NUM_INTFS-1:0]        ff_undrflw;
    logic [NUM_INTFS*CNTR_W-1:0] ovrflw_cnt;
    logic [NUM_INTFS*CNTR_W-1:0] undrflw_cnt;
    logic                        err_irq;

    modport master (
        output clear_flags, ff_wren, ff_full, ff_rden, ff_empty, irq_mask,
        input  ff_ovrflw, ff_undrflw, ovrflw_cnt, undrflw_cnt, err_irq
    );

    modport slave (
        input  clear_flags, ff_wren, ff_full, ff_rden, ff_empty, irq_mask,
        output ff_ovrflw, ff_undrflw, ovrflw_cnt, undrflw_cnt, err_irq
    );
endinterface

// File: rtl/ff_err_mon.sv
// ff_err_mon: per-channel FIFO overflow/underflow flags, saturating error counters (FF_ERR_MON_CNTR_EN) and maskable irq
module ff_err_mon #(
    parameter int NUM_INTFS = 1,
    parameter int CNTR_W    = 8,
    parameter int STICKY    = 1
) (
    input logic         clk,
    input logic         clk_rst,
    ff_err_mon_if.slave bus
);
    logic [NUM_INTFS-1:0] ovr_evt;
    logic [NUM_INTFS-1:0] und_evt;
    logic [NUM_INTFS-1:0] ovr;
    logic [NUM_INTFS-1:0] und;
    logic                 irq;

    assign ovr_evt = bus.ff_wren & bus.ff_full;
    assign und_evt = bus.ff_rden & bus.ff_empty;

    // Flags: sticky mode holds until cleared, an event in the clear cycle wins; pulse mode just registers the event
    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            ovr <= '0;
            und <= '0;
        end else begin
            ovr <= (STICKY != 0) ? (ovr_evt | (ovr & ~bus.clear_flags)) : ovr_evt;
            und <= (STICKY != 0) ? (und_evt | (und & ~bus.clear_flags)) : und_evt;
        end
    end

    // Interrupt is registered from the registered flags, so it trails them by one cycle
    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) irq <= 1'b0;
        else         irq <= |((ovr | und) & ~bus.irq_mask);
    end

    assign bus.ff_ovrflw  = ovr;
    assign bus.ff_undrflw = und;
    assign bus.err_irq    = irq;

`ifdef FF_ERR_MON_CNTR_EN
    logic [NUM_INTFS*CNTR_W-1:0] oc;
    logic [NUM_INTFS*CNTR_W-1:0] uc;

    // An event in the clear cycle restarts the count at 1; counts stick at all-ones
    function automatic logic [CNTR_W-1:0] cnt_next(input logic [CNTR_W-1:0] c, input logic evt, input logic clr);
        return evt ? (clr ? CNTR_W'(1) : (&c ? c : c + 1'b1)) : (clr ? '0 : c);
    endfunction

    // Per-channel saturating event counters, same latency as the flags
    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            oc <= '0;
            uc <= '0;
        end else begin
            for (int i = 0; i < NUM_INTFS; i++) begin
                oc[i*CNTR_W +: CNTR_W] <= cnt_next(oc[i*CNTR_W +: CNTR_W], ovr_evt[i], bus.clear_flags[i]);
                uc[i*CNTR_W +: CNTR_W] <= cnt_next(uc[i*CNTR_W +: CNTR_W], und_evt[i], bus.clear_flags[i]);
            end
        end
    end

    assign bus.ovrflw_cnt  = oc;
    assign bus.undrflw_cnt = uc;
`else
    assign bus.ovrflw_cnt  = '0;
    assign bus.undrflw_cnt = '0;
`endif
endmodule

// File: doc/ff_err_mon.md
FF_ERR_MON -- requirements
Module: ff_err_mon

Interface
- REQ-001 Parameter NUM_INTFS, default 1, number of monitored FIFO channels.
- REQ-002 Parameter CNTR_W, default 8, width of each per-channel error counter.
- REQ-003 Parameter STICKY, default 1: 1 = flags held until cleared; 0 = flags are single-cycle event pulses.
- REQ-004 clk  input  1  single clock; all logic on its rising edge.
- REQ-005 clk_rst  input  1  asynchronous, active-high reset.
- REQ-006 clear_flags  input  NUM_INTFS  per-channel clear of flags and counters, sampled on clk.
- REQ-007 ff_wren  input  NUM_INTFS  FIFO write enable per channel.
- REQ-008 ff_full  input  NUM_INTFS  FIFO full per channel.
- REQ-009 ff_rden  input  NUM_INTFS  FIFO read enable per channel.
- REQ-010 ff_empty  input  NUM_INTFS  FIFO empty per channel.
- REQ-011 irq_mask  input  NUM_INTFS  1 = channel excluded from err_irq.
- REQ-012 ff_ovrflw  output  NUM_INTFS  overflow flag per channel, registered.
- REQ-013 ff_undrflw  output  NUM_INTFS  underflow flag per channel, registered.
- REQ-014 ovrflw_cnt  output  NUM_INTFS*CNTR_W  packed overflow counters, channel i at [i*CNTR_W +: CNTR_W].
- REQ-015 undrflw_cnt  output  NUM_INTFS*CNTR_W  packed underflow counters, same packing.
- REQ-016 err_irq  output  1  registered OR of unmasked channel flags.

Function
- REQ-017 Overflow event for channel i is ff_wren[i] & ff_full[i]; underflow event is ff_rden[i] & ff_empty[i].
- REQ-018 Flag latency: an event in cycle N is visible on the flag in cycle N+1.
- REQ-019 STICKY=1: a flag sets on an event and holds until clear_flags[i]; STICKY=0: flag equals the registered event.
- REQ-020 clear_flags[i] in cycle N gives a zero flag and zero counters in cycle N+1, unless an event occurs in cycle N.
- REQ-021 Simultaneous clear and event: the event wins; the flag is 1 and the counter is 1 in cycle N+1.
- REQ-022 Counters increment by 1 per event cycle with the same latency as the flags, independent of STICKY.
- REQ-023 Counters saturate at 2^CNTR_W-1 and never wrap.
- REQ-024 Overflow and underflow of one channel in the same cycle are both recorded independently.
- REQ-025 Channels are fully independent; a clear on channel i does not affect any other channel.
- REQ-026 err_irq in cycle N+1 = OR over i of ((ff_ovrflw[i] | ff_undrflw[i]) & ~irq_mask[i]) evaluated in cycle N, giving one extra cycle of latency after the flags.
- REQ-027 Changing irq_mask does not alter flags or counters.

Reset
- REQ-028 clk_rst asserted immediately drives ff_ovrflw, ff_undrflw, ovrflw_cnt, undrflw_cnt and err_irq to 0, regardless of clk.
- REQ-029 Reset asserted during event streaming discards all accumulated state.
- REQ-030 Counting resumes on the first rising clk edge after clk_rst deasserts.

Configuration
- REQ-031 Macro FF_ERR_MON_CNTR_EN defined: the counters of REQ-022/023 are implemented.
- REQ-032 Macro FF_ERR_MON_CNTR_EN undefined: no counter registers are built, ovrflw_cnt and undrflw_cnt are tied to 0, and flag and irq behaviour is unchanged.

Verification
- REQ-033 NUM_INTFS=2, STICKY=1: ff_wren[0]=ff_full[0]=1 for 1 cycle -> ff_ovrflw=2'b01 from the next cycle, held; ovrflw_cnt[7:0]=1; err_irq=1 one cycle later.
- REQ-034 CNTR_W=4: 20 consecutive underflow cycles on channel 1 -> undrflw_cnt[7:4] reaches 15 and stays at 15.
- REQ-035 clear_flags[0] in the same cycle as an overflow on channel 0 with count 5 -> next cycle ff_ovrflw[0]=1 and count=1.
- REQ-036 STICKY=0: overflow events in cycles 3 and 5 -> ff_ovrflw[0] high only in cycles 4 and 6.
- REQ-037 irq_mask=2'b01 with only channel 0 flagged -> err_irq=0; irq_mask=2'b00 -> err_irq=1 one cycle later.
- REQ-038 clk_rst pulsed mid-burst with count 9 -> all outputs 0 asynchronously; FF_ERR_MON_CNTR_EN undefined -> counters read 0 throughout.
